cv_pe_scheduler: RTL and testbench
==================================

// Module: cv_pe_scheduler
// PURPOSE
//  Sequences the PE array for one tile command: configures the target PE (or all PEs via broadcast),
//  then issues load_weight / load_input / store_output and waits on idle between phases.
//  Sits between the layer-level command queue and the PE array's shared id/broadcast/cfg/control bus.
//  One command in flight; completion is reported on a done strobe carrying the PE id.
// PARAMETERS
//  NUM_PE          16     number of PEs on the bus (idle vector width); must be <= 256
//  TIMEOUT_CYCLES  65535  max cycles spent in any wait state (CV_SCHED_TIMEOUT_EN only)
// PORTS
//  clk              in   1        clock
//  rst              in   1        reset, asynchronous, active-high
//  cmd_valid        in   1        tile command offered
//  cmd_ready        out  1        scheduler accepts command (high only in S_IDLE)
//  cmd_pe_id        in   8        target PE id
//  cmd_broadcast    in   1        configure/control all PEs
//  cmd_skip_weight  in   1        omit the load_weight phase (weights already resident)
//  cmd_cfg          in   104      {Iext,Oext,Hext,Wext,Iori,Oori,Hori,Wori}, 13 bits each, Iext in MSBs
//  pe_id            out  8        id driven onto the PE bus
//  pe_broadcast     out  1        broadcast qualifier on the PE bus
//  pe_cfg           out  1        one-cycle config strobe
//  pe_cfg_bus       out  104      registered copy of cmd_cfg
//  pe_load_weight   out  1        one-cycle phase start strobe
//  pe_load_input    out  1        one-cycle phase start strobe
//  pe_store_output  out  1        one-cycle phase start strobe
//  pe_idle          in   NUM_PE   per-PE idle
//  done_valid       out  1        one-cycle completion strobe
//  done_pe_id       out  8        PE id of completed command
//  done_bad         out  1        qualifies done_valid: command was invalid or aborted
//  busy             out  1        high in every state except S_IDLE
//  tiles_done       out  16       count of good completions, wraps 0xFFFF->0
//  err              out  1        sticky timeout flag (CV_SCHED_TIMEOUT_EN only, else tied 0)
// BEHAVIOUR
//  - All outputs registered. Reset: all strobes, busy, done_*, err = 0; pe_id, pe_cfg_bus, tiles_done = 0;
//    state = S_IDLE. Reset mid-command abandons it silently (no done).
//  - Accept on cmd_valid & cmd_ready; latch id, broadcast, skip_weight, cfg.
//  - States: S_IDLE -> S_CFG -> [S_LW -> S_LW_G -> S_LW_W] -> S_LI -> S_LI_G -> S_LI_W
//    -> S_ST -> S_ST_G -> S_ST_W -> S_DONE -> S_IDLE. Bracketed phase skipped when skip_weight=1.
//  - S_CFG: pe_cfg=1 for exactly one cycle with pe_id/pe_broadcast/pe_cfg_bus valid.
//  - Phase states (S_LW/S_LI/S_ST): corresponding strobe high one cycle. _G (guard): one cycle,
//    idle ignored (PE idle drops within one cycle of strobe). _W: wait until selected idle == 1.
//  - Selected idle: broadcast -> AND of all pe_idle; else pe_idle[pe_id].
//  - pe_id/pe_broadcast held stable from S_CFG through S_DONE.
//  - Invalid command (!broadcast & cmd_pe_id >= NUM_PE): accepted, no PE strobes, goes S_DONE
//    next cycle with done_bad=1; tiles_done not incremented.
//  - S_DONE: done_valid=1, done_pe_id=latched id; tiles_done += 1 when done_bad=0. Minimum command
//    latency (cmd accept to done_valid): 9 cycles with skip_weight, 12 without, plus PE busy time.
//  - cmd_ready is 0 in S_DONE; back-to-back command accepted the cycle after done_valid.
// CONFIGURATION
//  CV_SCHED_TIMEOUT_EN defined: 32-bit wait counter cleared on entering each _W state; if it
//   reaches TIMEOUT_CYCLES, go to S_DONE with done_bad=1 and set err (sticky until rst).
//  Undefined: _W states wait indefinitely; err tied to 0; no counter logic.
// STRUCTURE
//  Package cv_sched_pkg: state enum, CFG_W=13, CFG_BUS_W=104, per-field bit offsets of cfg bus.
//  Sub-module cv_sched_idle_sel: NUM_PE idle vector + id + broadcast -> selected idle (combinational,
//   registered in parent). Everything else in cv_pe_scheduler.
// TESTING
//  1. id=3, skip=0, PE3 idle drops 5 cycles per phase -> strobes cfg,LW,LI,ST in order, done_pe_id=3, tiles_done=1.
//  2. skip_weight=1 -> no pe_load_weight pulse; done_valid at accept+9 with zero-delay idle.
//  3. broadcast=1, PE7 idle held low 20 cycles after LI -> scheduler stays in S_LI_W until PE7 idles.
//  4. id=200 with NUM_PE=16 -> no PE strobes, done_valid at accept+2, done_bad=1, tiles_done unchanged.
//  5. rst asserted during S_LI_W -> outputs 0 immediately, no done, next command completes normally.
//  6. CV_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=100, idle stuck low -> done_bad=1 and err=1 at 100 cycles in wait.

Source files
------------

// File: rtl/cv_sched_pkg.sv
// Shared types and constants for the PE-array tile scheduler.
// Holds the FSM state encoding and the field layout of the 104-bit tile
// configuration bus: {Iext,Oext,Hext,Wext,Iori,Oori,Hori,Wori}, 13 bits each.
package cv_sched_pkg;

  localparam int CFG_W     = 13;
  localparam int CFG_BUS_W = 8 * CFG_W;

  localparam int WORI_LSB = 0 * CFG_W;
  localparam int HORI_LSB = 1 * CFG_W;
  localparam int OORI_LSB = 2 * CFG_W;
  localparam int IORI_LSB = 3 * CFG_W;
  localparam int WEXT_LSB = 4 * CFG_W;
  localparam int HEXT_LSB = 5 * CFG_W;
  localparam int OEXT_LSB = 6 * CFG_W;
  localparam int IEXT_LSB = 7 * CFG_W;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG,
    S_LW,
    S_LW_G,
    S_LW_W,
    S_LI,
    S_LI_G,
    S_LI_W,
    S_ST,
    S_ST_G,
    S_ST_W,
    S_DONE
  } sched_state_e;

  // True for the states that block on the selected PE idle signal.
  function automatic logic is_wait_state(sched_state_e s);
    return (s == S_LW_W) || (s == S_LI_W) || (s == S_ST_W);
  endfunction

endpackage

// File: rtl/cv_sched_idle_sel.sv
// Idle selector for the PE scheduler.
// Reduces the per-PE idle vector to the single idle bit the scheduler waits on:
// the AND of every PE for a broadcast command, otherwise the addressed PE.
// An id beyond the array reads as busy; such commands never reach a wait state.
module cv_sched_idle_sel #(
  parameter int NUM_PE = 16
) (
  input  logic [NUM_PE-1:0] pe_idle_i,
  input  logic [7:0]        pe_id_i,
  input  logic              broadcast_i,
  output logic              sel_idle_o
);

  logic targetIdle;

  // Mux the addressed PE's idle bit, then pick between it and the all-PE AND.
  always_comb begin
    targetIdle = 1'b0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (pe_id_i == 8'(i)) begin
        targetIdle = pe_idle_i[i];
      end
    end
    sel_idle_o = broadcast_i ? (&pe_idle_i) : targetIdle;
  end

endmodule

// File: rtl/cv_pe_scheduler.sv
// Tile-command scheduler for the PE array.
// Accepts one tile command at a time, configures the target PE (or all PEs on
// broadcast), then runs the load_weight / load_input / store_output phases,
// waiting for the selected PE idle after each, and reports completion on a
// one-cycle done strobe. Every output is driven from a register.
// Optional feature: define CV_SCHED_TIMEOUT_EN to bound each wait state by
// TIMEOUT_CYCLES; an expiry aborts the command (done_bad) and sets sticky err.
module cv_pe_scheduler
  import cv_sched_pkg::*;
#(
  parameter int NUM_PE         = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [7:0]           cmd_pe_id,
  input  logic                 cmd_broadcast,
  input  logic                 cmd_skip_weight,
  input  logic [CFG_BUS_W-1:0] cmd_cfg,
  output logic [7:0]           pe_id,
  output logic                 pe_broadcast,
  output logic                 pe_cfg,
  output logic [CFG_BUS_W-1:0] pe_cfg_bus,
  output logic                 pe_load_weight,
  output logic                 pe_load_input,
  output logic                 pe_store_output,
  input  logic [NUM_PE-1:0]    pe_idle,
  output logic                 done_valid,
  output logic [7:0]           done_pe_id,
  output logic                 done_bad,
  output logic                 busy,
  output logic [15:0]          tiles_done,
  output logic                 err
);

  sched_state_e state_q, state_d;

  logic [7:0]           peId_q;
  logic                 broadcast_q;
  logic                 skipWeight_q;
  logic [CFG_BUS_W-1:0] cfg_q;
  logic                 bad_q, bad_d;
  logic                 selIdle, selIdle_q;

  logic                 cmdReady_q;
  logic                 peCfg_q;
  logic                 loadWeight_q;
  logic                 loadInput_q;
  logic                 storeOutput_q;
  logic                 doneValid_q;
  logic                 doneBad_q;
  logic                 busy_q;
  logic [15:0]          tiles_q;

  logic                 acceptCmd;
  logic                 invalidCmd;
  logic                 timeoutHit;

  assign acceptCmd  = cmd_valid && cmdReady_q;
  assign invalidCmd = !cmd_broadcast && ({1'b0, cmd_pe_id} >= 9'(NUM_PE));

  cv_sched_idle_sel #(
    .NUM_PE(NUM_PE)
  ) u_idle_sel (
    .pe_idle_i  (pe_idle),
    .pe_id_i    (peId_q),
    .broadcast_i(broadcast_q),
    .sel_idle_o (selIdle)
  );

`ifdef CV_SCHED_TIMEOUT_EN
  logic [31:0] waitCnt_q, waitCnt_d;
  logic        err_q;

  // The counter holds the number of cycles already spent in the current wait
  // state, so the expiry fires on the TIMEOUT_CYCLES-th wait cycle.
  assign timeoutHit = (waitCnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    waitCnt_d = '0;
    if (is_wait_state(state_q) && (state_d == state_q)) begin
      waitCnt_d = waitCnt_q + 32'd1;
    end
  end

  // Wait counter restarts on every wait-state entry; err stays set until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waitCnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      waitCnt_q <= waitCnt_d;
      if (is_wait_state(state_q) && !selIdle_q && timeoutHit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  logic unusedTimeout;

  assign unusedTimeout = ^32'(TIMEOUT_CYCLES);
  assign timeoutHit    = 1'b0;
  assign err           = 1'b0;
`endif

  // Next-state logic: phase sequencing, idle waits and abort paths.
  always_comb begin
    state_d = state_q;
    bad_d   = bad_q;
    case (state_q)
      S_IDLE: begin
        if (acceptCmd) begin
          bad_d   = invalidCmd;
          state_d = invalidCmd ? S_DONE : S_CFG;
        end
      end
      S_CFG:  state_d = skipWeight_q ? S_LI : S_LW;
      S_LW:   state_d = S_LW_G;
      S_LW_G: state_d = S_LW_W;
      S_LW_W: begin
        if (selIdle_q) begin
          state_d = S_LI;
        end else if (timeoutHit) begin
          state_d = S_DONE;
          bad_d   = 1'b1;
        end
      end
      S_LI:   state_d = S_LI_G;
      S_LI_G: state_d = S_LI_W;
      S_LI_W: begin
        if (selIdle_q) begin
          state_d = S_ST;
        end else if (timeoutHit) begin
          state_d = S_DONE;
          bad_d   = 1'b1;
        end
      end
      S_ST:   state_d = S_ST_G;
      S_ST_G: state_d = S_ST_W;
      S_ST_W: begin
        if (selIdle_q || timeoutHit) begin
          state_d = S_DONE;
          bad_d   = bad_q || !selIdle_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register plus the command fields latched at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bad_q        <= 1'b0;
      peId_q       <= '0;
      broadcast_q  <= 1'b0;
      skipWeight_q <= 1'b0;
      cfg_q        <= '0;
      selIdle_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bad_q     <= bad_d;
      selIdle_q <= selIdle;
      if (acceptCmd) begin
        peId_q       <= cmd_pe_id;
        broadcast_q  <= cmd_broadcast;
        skipWeight_q <= cmd_skip_weight;
        cfg_q        <= cmd_cfg;
      end
    end
  end

  // Output registers: PE strobes track the state being entered; the done
  // report and ready come out the cycle after S_DONE so a new command can
  // only be accepted once the completion has been seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmdReady_q    <= 1'b0;
      peCfg_q       <= 1'b0;
      loadWeight_q  <= 1'b0;
      loadInput_q   <= 1'b0;
      storeOutput_q <= 1'b0;
      doneValid_q   <= 1'b0;
      doneBad_q     <= 1'b0;
      busy_q        <= 1'b0;
      tiles_q       <= '0;
    end else begin
      cmdReady_q    <= (state_d == S_IDLE) && (state_q != S_DONE);
      peCfg_q       <= (state_d == S_CFG);
      loadWeight_q  <= (state_d == S_LW);
      loadInput_q   <= (state_d == S_LI);
      storeOutput_q <= (state_d == S_ST);
      busy_q        <= (state_d != S_IDLE);
      doneValid_q   <= (state_q == S_DONE);
      doneBad_q     <= (state_q == S_DONE) && bad_q;
      if ((state_q == S_DONE) && !bad_q) begin
        tiles_q <= tiles_q + 16'd1;
      end
    end
  end

  assign cmd_ready       = cmdReady_q;
  assign pe_id           = peId_q;
  assign pe_broadcast    = broadcast_q;
  assign pe_cfg          = peCfg_q;
  assign pe_cfg_bus      = cfg_q;
  assign pe_load_weight  = loadWeight_q;
  assign pe_load_input   = loadInput_q;
  assign pe_store_output = storeOutput_q;
  assign done_valid      = doneValid_q;
  assign done_pe_id      = peId_q;
  assign done_bad        = doneBad_q;
  assign busy            = busy_q;
  assign tiles_done      = tiles_q;

endmodule

// File: tb/tb_cv_pe_scheduler.sv
// Self-checking bench for cv_pe_scheduler.
// A behavioural PE array drops idle for a programmed number of cycles after
// each phase strobe; a command-level model predicts latency, strobe order,
// done fields, tile count and err from those busy times.
// Honours CV_SCHED_TIMEOUT_EN for the wait-timeout scenario.
module tb_cv_pe_scheduler;
  import cv_sched_pkg::*;

  localparam int NUM_PE  = 16;
  localparam int TIMEOUT = 100;
`ifdef CV_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [7:0]           cmd_pe_id;
  logic                 cmd_broadcast;
  logic                 cmd_skip_weight;
  logic [CFG_BUS_W-1:0] cmd_cfg;
  logic [7:0]           pe_id;
  logic                 pe_broadcast;
  logic                 pe_cfg;
  logic [CFG_BUS_W-1:0] pe_cfg_bus;
  logic                 pe_load_weight;
  logic                 pe_load_input;
  logic                 pe_store_output;
  logic [NUM_PE-1:0]    pe_idle;
  logic                 done_valid;
  logic [7:0]           done_pe_id;
  logic                 done_bad;
  logic                 busy;
  logic [15:0]          tiles_done;
  logic                 err;

  int assertCount = 0;
  int failCount   = 0;
  int peDelay [NUM_PE][3];
  int idleCnt [NUM_PE];
  logic [15:0] expTiles;
  logic        expErr;

  cv_pe_scheduler #(
    .NUM_PE(NUM_PE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_pe_id      (cmd_pe_id),
    .cmd_broadcast  (cmd_broadcast),
    .cmd_skip_weight(cmd_skip_weight),
    .cmd_cfg        (cmd_cfg),
    .pe_id          (pe_id),
    .pe_broadcast   (pe_broadcast),
    .pe_cfg         (pe_cfg),
    .pe_cfg_bus     (pe_cfg_bus),
    .pe_load_weight (pe_load_weight),
    .pe_load_input  (pe_load_input),
    .pe_store_output(pe_store_output),
    .pe_idle        (pe_idle),
    .done_valid     (done_valid),
    .done_pe_id     (done_pe_id),
    .done_bad       (done_bad),
    .busy           (busy),
    .tiles_done     (tiles_done),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Behavioural PE array: an addressed PE goes busy for peDelay cycles after a strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PE; i++) idleCnt[i] <= 0;
    end else begin
      for (int i = 0; i < NUM_PE; i++) begin
        if ((pe_broadcast || pe_id == 8'(i)) && (pe_load_weight || pe_load_input || pe_store_output))
          idleCnt[i] <= pe_load_weight ? peDelay[i][0] : (pe_load_input ? peDelay[i][1] : peDelay[i][2]);
        else if (idleCnt[i] > 0)
          idleCnt[i] <= idleCnt[i] - 1;
      end
    end
  end

  always_comb begin
    pe_idle = '0;
    for (int i = 0; i < NUM_PE; i++) pe_idle[i] = (idleCnt[i] == 0);
  end

  // Hard stop if something wedges beyond every per-wait bound.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
    end
  endtask

  function automatic int phaseBusy(input logic [7:0] id, input logic bc, input int ph);
    int m = 0;
    if (bc) begin
      for (int i = 0; i < NUM_PE; i++) if (peDelay[i][ph] > m) m = peDelay[i][ph];
    end else begin
      m = peDelay[id][ph];
    end
    return m;
  endfunction

  // Command-level model: first strobe two cycles after accept, each phase costs
  // strobe + guard + one wait cycle plus the PE busy time, done one cycle after S_DONE.
  function automatic void modelCmd(input logic [7:0] id, input logic bc, input logic skip,
                                   output int lat, output bit bad, output bit timedOut);
    int s = 2;
    int d;
    lat = 0; bad = 1'b0; timedOut = 1'b0;
    if (!bc && id >= 8'(NUM_PE)) begin
      lat = 2; bad = 1'b1;
      return;
    end
    for (int ph = (skip ? 1 : 0); ph < 3; ph++) begin
      d = phaseBusy(id, bc, ph);
      if (TO_EN && d >= TIMEOUT) begin
        lat = s + 3 + TIMEOUT; bad = 1'b1; timedOut = 1'b1;
        return;
      end
      if (ph == 2) lat = s + 4 + d;
      else s = s + 3 + d;
    end
  endfunction

  task automatic clearDelays();
    for (int i = 0; i < NUM_PE; i++) for (int p = 0; p < 3; p++) peDelay[i][p] = 0;
  endtask

  function automatic logic [CFG_BUS_W-1:0] randCfg();
    logic [CFG_BUS_W-1:0] c = '0;
    c[WORI_LSB +: CFG_W] = 13'($urandom);
    c[HORI_LSB +: CFG_W] = 13'($urandom);
    c[OORI_LSB +: CFG_W] = 13'($urandom);
    c[IORI_LSB +: CFG_W] = 13'($urandom);
    c[WEXT_LSB +: CFG_W] = 13'($urandom);
    c[HEXT_LSB +: CFG_W] = 13'($urandom);
    c[OEXT_LSB +: CFG_W] = 13'($urandom);
    c[IEXT_LSB +: CFG_W] = 13'($urandom);
    return c;
  endfunction

  // Wait for ready at a negedge, hand over the command for one cycle.
  task automatic driveCmd(input logic [7:0] id, input logic bc, input logic skip, input logic [CFG_BUS_W-1:0] cfg);
    int waitCnt = 0;
    while (cmd_ready !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 50) checkOutput("readyWait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid       = 1'b1;
    cmd_pe_id       = id;
    cmd_broadcast   = bc;
    cmd_skip_weight = skip;
    cmd_cfg         = cfg;
    @(negedge clk);
    cmd_valid       = 1'b0;
  endtask

  // Issue one command and check everything observable up to its completion.
  task automatic applyStimulus(input logic [7:0] id, input logic bc, input logic skip, input logic [CFG_BUS_W-1:0] cfg);
    int expLat, lat, k, busyCnt, readyCnt, idErr, cfgErr;
    bit expBad, expTo, seen;
    logic [31:0] seq, expSeq;
    logic obsBad;
    logic [7:0] obsId;
    modelCmd(id, bc, skip, expLat, expBad, expTo);
    if (expBad) expSeq = 32'd0;
    else if (skip) expSeq = (1 * 64) + (3 * 8) + 4;
    else expSeq = (1 * 512) + (2 * 64) + (3 * 8) + 4;
    driveCmd(id, bc, skip, cfg);
    k = 1; seen = 1'b0; lat = 0; seq = 0;
    busyCnt = 0; readyCnt = 0; idErr = 0; cfgErr = 0; obsBad = 1'b0; obsId = 8'd0;
    while (!seen && k <= expLat + 30) begin
      if (pe_cfg)          seq = seq * 8 + 1;
      if (pe_load_weight)  seq = seq * 8 + 2;
      if (pe_load_input)   seq = seq * 8 + 3;
      if (pe_store_output) seq = seq * 8 + 4;
      if (busy) busyCnt++;
      if (cmd_ready) readyCnt++;
      if (pe_id !== id || pe_broadcast !== bc) idErr++;
      if (pe_cfg && pe_cfg_bus !== cfg) cfgErr++;
      if (done_valid) begin
        seen = 1'b1; lat = k; obsBad = done_bad; obsId = done_pe_id;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    if (!expBad) expTiles = expTiles + 16'd1;
    if (expTo) expErr = 1'b1;
    checkOutput("doneLatency", lat, expLat);
    checkOutput("strobeOrder", seq, expSeq);
    checkOutput("donePeId", {24'd0, obsId}, {24'd0, id});
    checkOutput("doneBad", {31'd0, obsBad}, {31'd0, expBad});
    checkOutput("tilesDone", {16'd0, tiles_done}, {16'd0, expTiles});
    checkOutput("errFlag", {31'd0, err}, {31'd0, expErr});
    checkOutput("busyCycles", busyCnt, expLat - 1);
    checkOutput("readyWhileBusy", readyCnt, 0);
    checkOutput("idStable", idErr, 0);
    checkOutput("cfgBus", cfgErr, 0);
    @(negedge clk);
    checkOutput("doneOneShot", {31'd0, done_valid}, 32'd0);
    checkOutput("readyAfterDone", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int doneCnt;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_pe_id = '0; cmd_broadcast = 1'b0; cmd_skip_weight = 1'b0; cmd_cfg = '0;
    expTiles = '0; expErr = 1'b0;
    clearDelays();
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstReady", {31'd0, cmd_ready}, 32'd0);
    checkOutput("rstDone", {30'd0, done_valid, done_bad}, 32'd0);
    checkOutput("rstStrobes", {28'd0, pe_cfg, pe_load_weight, pe_load_input, pe_store_output}, 32'd0);
    checkOutput("rstPeId", {23'd0, pe_broadcast, pe_id}, 32'd0);
    checkOutput("rstCfgBus", {31'd0, |pe_cfg_bus}, 32'd0);
    checkOutput("rstTiles", {16'd0, tiles_done}, 32'd0);
    checkOutput("rstErr", {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // PE3, full sequence, 5 busy cycles per phase.
    clearDelays();
    for (int p = 0; p < 3; p++) peDelay[3][p] = 5;
    applyStimulus(8'd3, 1'b0, 1'b0, randCfg());
    // Weights resident, PEs respond instantly.
    clearDelays();
    applyStimulus(8'd9, 1'b0, 1'b1, randCfg());
    // Broadcast with PE7 slow after load_input.
    clearDelays();
    peDelay[7][1] = 20;
    peDelay[2][1] = 3;
    applyStimulus(8'd0, 1'b1, 1'b0, randCfg());
    // Out-of-range id: rejected quickly, no strobes, no tile.
    applyStimulus(8'd200, 1'b0, 1'b0, randCfg());
    applyStimulus(8'd16, 1'b0, 1'b1, randCfg());
    // Highest valid id.
    clearDelays();
    peDelay[15][2] = 2;
    applyStimulus(8'd15, 1'b0, 1'b1, randCfg());

    // Randomized commands, some out of range, some broadcast.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] rid;
      logic rbc, rskip;
      rid   = 8'($urandom_range(0, 19));
      rbc   = ($urandom_range(0, 3) == 0);
      rskip = 1'($urandom_range(0, 1));
      for (int i = 0; i < NUM_PE; i++) for (int p = 0; p < 3; p++) peDelay[i][p] = $urandom_range(0, 4);
      applyStimulus(rid, rbc, rskip, randCfg());
    end

    // Reset while waiting on load_input: command is dropped without a done.
    clearDelays();
    peDelay[5][1] = 30;
    driveCmd(8'd5, 1'b0, 1'b1, randCfg());
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
    checkOutput("midRstOutputs", {25'd0, done_valid, pe_cfg, pe_load_weight, pe_load_input, pe_store_output, cmd_ready, err}, 32'd0);
    checkOutput("midRstPeId", {24'd0, pe_id}, 32'd0);
    checkOutput("midRstTiles", {16'd0, tiles_done}, 32'd0);
    expTiles = '0; expErr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    doneCnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_valid) doneCnt++;
    end
    checkOutput("noDoneAfterRst", doneCnt, 0);
    clearDelays();
    peDelay[5][1] = 4;
    applyStimulus(8'd5, 1'b0, 1'b0, randCfg());

`ifdef CV_SCHED_TIMEOUT_EN
    // PE2 never idles after load_input: wait state must abort.
    clearDelays();
    peDelay[2][1] = 1000;
    applyStimulus(8'd2, 1'b0, 1'b1, randCfg());
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
